// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - E-stage multiply/divide unit bus
//
// Groups the decoder/operand inputs and the busy/HI/LO outputs of muldiv_unit.
//   start    : launch the op selected by mdctr (single-cycle pulse)
//   mdctr    : 001 mult, 010 multu, 011 div, 100 divu, others no-op
//   a, b     : forwarded rs/rt operands
//   lowrite  : mtlo, LO <= a
//   hiwrite  : mthi, HI <= a
//   busy     : an operation is in flight
//   hi, lo   : architectural HI/LO registers
// master drives the request side (pipeline), slave is the unit itself.

interface muldiv_unit_if;
    logic        start;
    logic [2:0]  mdctr;
    logic [31:0] a;
    logic [31:0] b;
    logic        lowrite;
    logic        hiwrite;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, mdctr, a, b, lowrite, hiwrite,
        input  busy, hi, lo
    );

    modport slave (
        input  start, mdctr, a, b, lowrite, hiwrite,
        output busy, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle MIPS multiply/divide unit with HI/LO
//
// Models mult/multu/div/divu latency with a busy countdown and holds HI/LO.
// Ports:
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : muldiv_unit_if.slave (start/mdctr/a/b/lowrite/hiwrite in,
//           busy/hi/lo out; all outputs registered)
// Parameters:
//   MULT_CYCLES : busy duration for mult/multu
//   DIV_CYCLES  : busy duration for div/divu

module muldiv_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic          clk,
    input logic          reset,
    muldiv_unit_if.slave bus
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state;
    logic [CW-1:0] count;
    logic [2:0]  op;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;

    logic               valid_op;
    logic               a_neg;
    logic               b_neg;
    logic [31:0]        mag_a;
    logic [31:0]        mag_b;
    logic [31:0]        div_b;
    logic [31:0]        quo_mag;
    logic [31:0]        rem_mag;
    logic [31:0]        quo;
    logic [31:0]        rem;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;

    // Results are computed only from the latched operands so that operand
    // changes while busy cannot leak into HI/LO.
    always_comb begin
        valid_op = (bus.mdctr == OP_MULT) || (bus.mdctr == OP_MULTU) ||
                   (bus.mdctr == OP_DIV)  || (bus.mdctr == OP_DIVU);

        // Signed divide runs on magnitudes; 0x80000000 has magnitude 2^31 as an
        // unsigned value, so 0x80000000 / -1 naturally wraps back to 0x80000000.
        a_neg   = (op == OP_DIV) && a_q[31];
        b_neg   = (op == OP_DIV) && b_q[31];
        mag_a   = a_neg ? (~a_q + 32'd1) : a_q;
        mag_b   = b_neg ? (~b_q + 32'd1) : b_q;
        // Divisor of zero is replaced to keep the divider defined; the result
        // is discarded in that case.
        div_b   = (mag_b == 32'd0) ? 32'd1 : mag_b;
        quo_mag = mag_a / div_b;
        rem_mag = mag_a % div_b;
        quo     = (a_neg ^ b_neg) ? (~quo_mag + 32'd1) : quo_mag;
        rem     = a_neg ? (~rem_mag + 32'd1) : rem_mag;

        prod_s  = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
        prod_u  = {32'd0, a_q} * {32'd0, b_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            op    <= 3'b000;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            hi_q  <= 32'd0;
            lo_q  <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    // start takes priority over a same-cycle mthi/mtlo.
                    if (bus.start) begin
                        if (valid_op) begin
                            op    <= bus.mdctr;
                            a_q   <= bus.a;
                            b_q   <= bus.b;
                            count <= ((bus.mdctr == OP_DIV) || (bus.mdctr == OP_DIVU)) ?
                                     CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                            state <= BUSY;
                        end
                    end else begin
                        if (bus.hiwrite) hi_q <= bus.a;
                        if (bus.lowrite) lo_q <= bus.a;
                    end
                end
                BUSY: begin
                    // start/hiwrite/lowrite are deliberately not looked at here.
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state <= IDLE;
                        case (op)
                            OP_MULT:  {hi_q, lo_q} <= prod_s;
                            OP_MULTU: {hi_q, lo_q} <= prod_u;
                            OP_DIV, OP_DIVU: begin
                                if (b_q != 32'd0) begin
                                    hi_q <= rem;
                                    lo_q <= quo;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state == BUSY);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit

module tb_muldiv_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [63:0] sb_q[$];
    logic [63:0] exp_v;

    muldiv_unit_if bus();

    muldiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model written with the language's own signed/unsigned operators.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] x,
                                          input logic [31:0] y, input logic [31:0] h,
                                          input logic [31:0] l);
        longint sx, sy;
        int     ix, iy;
        case (op)
            3'b001: begin
                sx = longint'($signed(x));
                sy = longint'($signed(y));
                return 64'(sx * sy);
            end
            3'b010: return {32'd0, x} * {32'd0, y};
            3'b011: begin
                if (y == 32'd0) return {h, l};
                if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                ix = int'(x);
                iy = int'(y);
                return {32'(ix % iy), 32'(ix / iy)};
            end
            3'b100: begin
                if (y == 32'd0) return {h, l};
                return {x % y, x / y};
            end
            default: return {h, l};
        endcase
    endfunction

    // Called and returns at a negedge. Drives start, pushes the model result,
    // checks busy over the latency window and pops/compares when busy drops.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] x,
                          input logic [31:0] y, input bit interfere);
        int lat;
        lat = (op == 3'b011 || op == 3'b100) ? DC : MC;
        bus.start = 1'b1;
        bus.mdctr = op;
        bus.a     = x;
        bus.b     = y;
        exp_v = model(op, x, y, m_hi, m_lo);
        sb_q.push_back(exp_v);
        {m_hi, m_lo} = exp_v;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 1; i <= lat; i++) begin
            check({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
            if (interfere && i == 2) begin
                bus.start   = 1'b1;
                bus.mdctr   = 3'b011;
                bus.lowrite = 1'b1;
                bus.hiwrite = 1'b1;
                bus.a       = $urandom;
                bus.b       = $urandom;
            end else if (interfere && i == 3) begin
                bus.start   = 1'b0;
                bus.lowrite = 1'b0;
                bus.hiwrite = 1'b0;
                bus.a       = $urandom;
                bus.b       = $urandom;
            end
            @(negedge clk);
        end
        check({tag, "_idle"}, {31'd0, bus.busy}, 32'd0);
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            exp_v = sb_q.pop_front();
            check({tag, "_hi"}, bus.hi, exp_v[63:32]);
            check({tag, "_lo"}, bus.lo, exp_v[31:0]);
        end
    endtask

    task automatic move(input bit to_hi, input logic [31:0] v);
        bus.a       = v;
        bus.hiwrite = to_hi;
        bus.lowrite = !to_hi;
        if (to_hi) m_hi = v; else m_lo = v;
        @(negedge clk);
        bus.hiwrite = 1'b0;
        bus.lowrite = 1'b0;
        check(to_hi ? "mthi" : "mtlo", to_hi ? bus.hi : bus.lo, v);
    endtask

    initial begin
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.mdctr   = 3'b000;
        bus.a       = 32'd0;
        bus.b       = 32'd0;
        bus.lowrite = 1'b0;
        bus.hiwrite = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_hi", bus.hi, 32'd0);
        check("rst_lo", bus.lo, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op("mult", 3'b001, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("mult_hi_lit", bus.hi, 32'hFFFF_FFFF);
        check("mult_lo_lit", bus.lo, 32'hFFFF_FFFA);

        // Back-to-back ops: no dead cycle between them.
        run_op("multu", 3'b010, 32'hFFFF_FFFE, 32'd3, 1'b0);
        check("multu_hi_lit", bus.hi, 32'h0000_0002);
        check("multu_lo_lit", bus.lo, 32'hFFFF_FFFA);

        run_op("div", 3'b011, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("div_hi_lit", bus.hi, 32'hFFFF_FFFF);
        check("div_lo_lit", bus.lo, 32'hFFFF_FFFD);

        run_op("divu", 3'b100, 32'hFFFF_FFF9, 32'd2, 1'b0);
        check("divu_hi_lit", bus.hi, 32'h0000_0001);
        check("divu_lo_lit", bus.lo, 32'h7FFF_FFFC);

        move(1'b1, 32'h11);
        move(1'b0, 32'h22);
        run_op("divu0", 3'b100, 32'h1234_5678, 32'd0, 1'b0);
        check("divu0_hi_lit", bus.hi, 32'h11);
        check("divu0_lo_lit", bus.lo, 32'h22);
        run_op("div0", 3'b011, 32'h8765_4321, 32'd0, 1'b0);

        run_op("div_ovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        check("div_ovf_hi_lit", bus.hi, 32'h0);
        check("div_ovf_lo_lit", bus.lo, 32'h8000_0000);

        run_op("div_neg", 3'b011, 32'd100, 32'hFFFF_FFF9, 1'b0);

        // Invalid mdctr with start is ignored.
        bus.start = 1'b1;
        bus.mdctr = 3'b111;
        @(negedge clk);
        bus.start = 1'b0;
        check("bad_op_busy", {31'd0, bus.busy}, 32'd0);

        move(1'b1, 32'hABCD);

        run_op("mult_intf", 3'b001, 32'hFFFF_1234, 32'h0000_5678, 1'b1);

        for (int n = 0; n < 4; n++) begin
            run_op("rnd_mult", 3'b001, $urandom, $urandom, 1'b0);
            run_op("rnd_divu", 3'b100, $urandom, $urandom_range(1, 32'hFFFF), 1'b0);
            run_op("rnd_div", 3'b011, $urandom, $urandom_range(1, 32'hFFFF), 1'b0);
        end

        // Reset in busy cycle 4 of a divide.
        bus.start = 1'b1;
        bus.mdctr = 3'b011;
        bus.a     = 32'd1000;
        bus.b     = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 1; i < 4; i++) begin
            check("rstmid_busy", {31'd0, bus.busy}, 32'd1);
            @(negedge clk);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        check("rstmid_busy0", {31'd0, bus.busy}, 32'd0);
        check("rstmid_hi", bus.hi, 32'd0);
        check("rstmid_lo", bus.lo, 32'd0);

        run_op("mult67", 3'b001, 32'd6, 32'd7, 1'b0);
        check("mult67_lo_lit", bus.lo, 32'd42);
        check("mult67_hi_lit", bus.hi, 32'd0);

        check("sb_drained", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Multi-cycle multiply/divide unit with HI/LO registers in the E stage, directly downstream of the E-stage main control decoder. It consumes that decoder's `start`, `mdctr`, `lowrite` and `hiwrite` together with the forwarded E-stage operands. It models MIPS mult/multu/div/divu latency with a busy countdown and holds the architectural HI/LO registers. Its `busy` output and the decoder's `start` output feed the hazard unit, which stalls md-class instructions.

## Interface
Parameters:
- `MULT_CYCLES`, 5: busy duration for mult/multu.
- `DIV_CYCLES`, 10: busy duration for div/divu.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: launch the operation selected by `mdctr`; single-cycle pulse.
- `mdctr` in 3: 3'b001 mult, 3'b010 multu, 3'b011 div, 3'b100 divu; other values mean no operation.
- `a` in 32: rs operand (forwarded value).
- `b` in 32: rt operand (forwarded value).
- `lowrite` in 1: mtlo, LO <= `a`.
- `hiwrite` in 1: mthi, HI <= `a`.
- `busy` out 1: an operation is in flight.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- Reset: `busy`=0, `hi`=0, `lo`=0, countdown=0, latched operands and op cleared.
- Idle state: `busy`=0.
  - Edge with `start`=1 and a valid `mdctr`:
    - Latch `a`, `b` and the op.
    - Load countdown with the latency L (MULT_CYCLES or DIV_CYCLES).
    - Go to BUSY.
  - `start`=1 with an invalid `mdctr`: ignored.
- BUSY state:
  - Each edge decrements the countdown.
  - On the edge where it reaches 0, write HI/LO, clear `busy` and return to Idle.
- Results:
  - mult: {HI,LO} = signed 64-bit `a`*`b`.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient, truncated toward zero. HI = remainder, with the sign of the dividend.
  - divu: unsigned LO = `a`/`b`, HI = `a`%`b`.
- Divide by zero (b=0, div or divu): the op still takes DIV_CYCLES. HI and LO are unchanged at completion.
- Signed div of 0x80000000 by 0xFFFFFFFF: LO=0x80000000, HI=0. No trap.
- Results depend only on the latched operands. Changes on `a`/`b` during BUSY have no effect.
- mthi/mtlo:
  - When not busy, `hiwrite`/`lowrite` write `a` to HI/LO at the next edge.
  - They are ignored while `busy`=1. The hazard unit prevents this case; the unit still guarantees no corruption.
- Simultaneous events:
  - `start` with `hiwrite`/`lowrite` in the same cycle: `start` wins; the move is ignored.
  - `start` while busy: ignored; the in-flight op completes unchanged.
- Reset mid-operation: the op is abandoned. `busy`=0 and HI=LO=0 after that edge.

## Timing
- `start` is sampled at edge k. `busy`=1 during cycles k+1 through k+L.
- HI/LO are written at edge k+L, and `busy` falls at the same edge.
- New values are visible from cycle k+L+1 onward.
- The next op can be sampled at edge k+L+1, when `start`=1 in the first non-busy cycle. There is no dead cycle.
- The hazard unit stalls mfhi/mflo/mthi/mtlo/md ops in D while (`start` | `busy`). The unit therefore never sees overlapping operations in normal flow.
- Writes from mthi/mtlo take 1 cycle. The registered `hi`/`lo` outputs are read combinationally by the E-stage mfhi/mflo select.
- All outputs are registered. There is no combinational path from inputs to `busy`/`hi`/`lo`.

## Test plan
- **mult.** `a`=0xFFFFFFFE (-2), `b`=3, mdctr=001, start at edge 0.
  - `busy`=1 in cycles 1–5; `busy`=0 in cycle 6.
  - HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- **multu.** Same operands, mdctr=010.
  - HI=0x00000002, LO=0xFFFFFFFA after 5 cycles.
- **div / divu.** `a`=-7 (0xFFFFFFF9), `b`=2.
  - div (011): after 10 busy cycles, LO=0xFFFFFFFD and HI=0xFFFFFFFF.
  - divu (100): LO=0x7FFFFFFC, HI=1.
- **Divide by zero.** HI=0x11, LO=0x22, divu with `b`=0.
  - `busy` lasts 10 cycles; HI/LO remain 0x11/0x22.
- **Moves and interference.**
  - mthi `a`=0xABCD: HI=0xABCD one cycle later.
  - Start a mult, then assert `lowrite` and a second `start` during busy, and wiggle `a`/`b`.
  - Result equals the original product; the second `start` and the move are ignored.
- **Reset mid-div.** Assert `reset` at busy cycle 4.
  - Next cycle: `busy`=0, HI=LO=0.
  - A following mult 6*7 yields LO=42.
